centroid_winner_seq: RTL and testbench
======================================

Name: centroid_winner_seq

Overview:
- Sequencer that finds the global winning (minimum-distance) centroid over NUM_GROUPS*8 centroids using one shared comparator_8cen_16bit.
- Accepts one group of eight 16-bit distances per handshake beat and keeps a running minimum and its index.
- After NUM_GROUPS beats, presents the winner index and distance on an output valid/ready handshake.
- Sits between the distance-calculation stage of a DeSTIN node and the belief/centroid-update logic.

Parameters:
- NUM_GROUPS, 4, number of 8-centroid groups per search (must be >=1).
- GRP_W, 2, width of the group counter; must equal max(1, clog2(NUM_GROUPS)).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  d_000..d_111 hold a valid distance group.
- in_ready  output  1  block accepts a group this cycle.
- d_000 .. d_111  input  16 each  eight unsigned distances; index bits [2:0] are the suffix.
- out_valid  output  1  winner result is valid.
- out_ready  input  1  consumer accepts the result.
- win_idx  output  GRP_W+3  global winner index {group, arg[2:0]}.
- win_dist  output  16  winner distance.
- busy  output  1  a search is in progress (ACCUM or DONE).

Behaviour:
- Reset (synchronous, active-high, takes priority over every other input): state=IDLE, grp_cnt=0, best_dist=16'hFFFF, best_idx=0, out_valid=0, win_idx=0, win_dist=0, busy=0. Reset mid-search discards the partial result, and no out_valid is produced for it.
- Comparator: a combinational comparator_8cen_16bit instance sees d_000..d_111 directly and yields grp_min (16 bit) and grp_arg (3 bit).
- Accept: a beat is accepted when in_valid && in_ready.
- in_ready = 1 in IDLE and ACCUM, 0 in DONE.
- States:
  - IDLE: on accept, best_dist<=grp_min, best_idx<={0,grp_arg}, grp_cnt<=1, busy<=1. If NUM_GROUPS==1, go to DONE; else go to ACCUM.
  - ACCUM: on accept, if grp_min < best_dist (strictly, unsigned), best_dist<=grp_min and best_idx<={grp_cnt,grp_arg}; otherwise hold. grp_cnt<=grp_cnt+1. When the accepted beat is group NUM_GROUPS-1, go to DONE and set grp_cnt<=0. With no accept, hold all state.
  - DONE: out_valid=1, win_idx=best_idx, win_dist=best_dist, computed from the final comparison including the last beat. When out_valid && out_ready: go to IDLE, out_valid<=0, busy<=0. Outputs stay stable while out_ready=0.
- Latency: out_valid rises on the clock edge that accepts the last group, so it is visible the cycle after. There is no accept in DONE, so back-to-back searches cost one bubble cycle.
- Ties:
  - Across groups, the earlier group wins (strict compare).
  - Within a group, the winner is grp_arg as produced by comparator_8cen_16bit; the block adds no re-resolution.
- Value range: distance 16'hFFFF is legal. If all distances are FFFF, the winner is the group-0 grp_arg, because IDLE loads rather than compares.
- in_valid while in DONE is ignored (in_ready=0) and does not alter state.
- grp_cnt never exceeds NUM_GROUPS-1 and never wraps inside a search.

Decomposition:
- Shared package (destin_defs) holds DIST_W=16, CEN_PER_GRP=8, CEN_IDX_W=3, and the state encoding IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
- Sub-modules: reuse the existing comparator_8cen_16bit as the datapath instance.
- Add one small sub-module, running_min_reg: holds best_dist/best_idx with a load/compare-update enable. This keeps the FSM module control-only.

Test Plan:
- Reset then four groups with distinct minima 500 (g0, arg 3), 120 (g1, arg 6), 300, 800 -> out_valid one cycle after the 4th accept, win_idx=5'b01110 (14), win_dist=120.
- Group minima equal, 77 in g0 arg 2 and g2 arg 5, others larger -> win_idx=2, win_dist=77 (earlier group wins).
- in_valid toggled 1,0,0,1,1,0,1 over four groups -> same result as gap-free feed; grp_cnt advances only on accepts.
- Result held with out_ready=0 for 5 cycles while in_valid=1 with new data -> in_ready=0, win_idx/win_dist stable; out_ready=1 -> IDLE, next search starts clean (min not carried over).
- reset asserted after 2 of 4 groups -> no out_valid; new 4-group search with minimum 9 at g3 arg 0 -> win_idx=24, win_dist=9.
- All distances 16'hFFFF -> win_dist=FFFF, win_idx in group 0 equal to the comparator's arg for that group.

Source files
------------

// File: rtl/destin_defs.sv
// Shared constants and FSM encoding for the DeSTIN winner search.
// Distance width, centroids per group, and sequencer state type.
package destin_defs;

  localparam int DIST_W      = 16;
  localparam int CEN_PER_GRP = 8;
  localparam int CEN_IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/centroid_winner_seq_if.sv
// Group-in / winner-out handshake bundle for centroid_winner_seq.
// master: distance producer + result consumer; slave: the sequencer.
interface centroid_winner_seq_if
  import destin_defs::*;
#(
  parameter int GRP_W = 2
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DIST_W-1:0] d_000;
  logic [DIST_W-1:0] d_001;
  logic [DIST_W-1:0] d_010;
  logic [DIST_W-1:0] d_011;
  logic [DIST_W-1:0] d_100;
  logic [DIST_W-1:0] d_101;
  logic [DIST_W-1:0] d_110;
  logic [DIST_W-1:0] d_111;
  logic              out_valid;
  logic              out_ready;
  logic [GRP_W+CEN_IDX_W-1:0] win_idx;
  logic [DIST_W-1:0] win_dist;
  logic              busy;

  modport master (
    output in_valid, d_000, d_001, d_010, d_011,
    output d_100, d_101, d_110, d_111, out_ready,
    input  in_ready, out_valid, win_idx, win_dist, busy
  );

  modport slave (
    input  in_valid, d_000, d_001, d_010, d_011,
    input  d_100, d_101, d_110, d_111, out_ready,
    output in_ready, out_valid, win_idx, win_dist, busy
  );

endinterface

// File: rtl/comparator_8cen_16bit.sv
// Combinational min/argmin over eight 16-bit distances.
// Ports: d_000..d_111 in; grp_min, grp_arg out. Ties go to the lowest index.
module comparator_8cen_16bit
  import destin_defs::*;
(
  input  logic [DIST_W-1:0]    d_000,
  input  logic [DIST_W-1:0]    d_001,
  input  logic [DIST_W-1:0]    d_010,
  input  logic [DIST_W-1:0]    d_011,
  input  logic [DIST_W-1:0]    d_100,
  input  logic [DIST_W-1:0]    d_101,
  input  logic [DIST_W-1:0]    d_110,
  input  logic [DIST_W-1:0]    d_111,
  output logic [DIST_W-1:0]    grp_min,
  output logic [CEN_IDX_W-1:0] grp_arg
);

  logic [DIST_W-1:0] dv [CEN_PER_GRP];

  assign dv[0] = d_000;
  assign dv[1] = d_001;
  assign dv[2] = d_010;
  assign dv[3] = d_011;
  assign dv[4] = d_100;
  assign dv[5] = d_101;
  assign dv[6] = d_110;
  assign dv[7] = d_111;

  always_comb begin
    grp_min = dv[0];
    grp_arg = '0;
    // strict compare keeps the earliest index on ties
    for (int i = 1; i < CEN_PER_GRP; i++) begin
      if (dv[i] < grp_min) begin
        grp_min = dv[i];
        grp_arg = CEN_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/running_min_reg.sv
// Holds the best distance/index seen so far in a search.
// Ports: clk, reset, load (unconditional), update (strict-less), cand_*, best_*.
module running_min_reg
  import destin_defs::*;
#(
  parameter int IDX_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              update,
  input  logic [DIST_W-1:0] cand_dist,
  input  logic [IDX_W-1:0]  cand_idx,
  output logic [DIST_W-1:0] best_dist,
  output logic [IDX_W-1:0]  best_idx
);

  logic take;

  // later groups must be strictly better to displace an earlier winner
  assign take = load || (update && (cand_dist < best_dist));

  always_ff @(posedge clk) begin
    if (reset) begin
      best_dist <= '1;
      best_idx  <= '0;
    end else if (take) begin
      best_dist <= cand_dist;
      best_idx  <= cand_idx;
    end
  end

endmodule

// File: rtl/centroid_winner_seq.sv
// Global min-distance centroid search over NUM_GROUPS groups of eight.
// Ports: clk, reset, bus (slave): group in, winner {grp,arg}/dist out, busy.
module centroid_winner_seq
  import destin_defs::*;
#(
  parameter int NUM_GROUPS = 4,
  parameter int GRP_W      = 2
) (
  input logic                   clk,
  input logic                   reset,
  centroid_winner_seq_if.slave  bus
);

  localparam int IDX_W = GRP_W + CEN_IDX_W;
  localparam logic [GRP_W-1:0] LAST_GRP =
    GRP_W'(NUM_GROUPS - 1);

  state_t               state;
  state_t               state_nx;
  logic [GRP_W-1:0]     grp_cnt;
  logic [GRP_W-1:0]     grp_cnt_nx;
  logic [DIST_W-1:0]    grp_min;
  logic [CEN_IDX_W-1:0] grp_arg;
  logic [DIST_W-1:0]    best_dist;
  logic [IDX_W-1:0]     best_idx;
  logic                 ld;
  logic                 upd;
  logic                 in_rdy;
  logic                 out_vld;
  logic                 bsy;
  logic                 accept;

  comparator_8cen_16bit u_cmp (
    .d_000   (bus.d_000),
    .d_001   (bus.d_001),
    .d_010   (bus.d_010),
    .d_011   (bus.d_011),
    .d_100   (bus.d_100),
    .d_101   (bus.d_101),
    .d_110   (bus.d_110),
    .d_111   (bus.d_111),
    .grp_min (grp_min),
    .grp_arg (grp_arg)
  );

  running_min_reg #(
    .IDX_W (IDX_W)
  ) u_min (
    .clk       (clk),
    .reset     (reset),
    .load      (ld),
    .update    (upd),
    .cand_dist (grp_min),
    .cand_idx  ({grp_cnt, grp_arg}),
    .best_dist (best_dist),
    .best_idx  (best_idx)
  );

  assign accept = bus.in_valid && in_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grp_cnt <= '0;
    end else begin
      state   <= state_nx;
      grp_cnt <= grp_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    grp_cnt_nx = grp_cnt;
    ld         = 1'b0;
    upd        = 1'b0;
    in_rdy     = 1'b0;
    out_vld    = 1'b0;
    bsy        = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        in_rdy = 1'b1;
        if (accept) begin
          // first group loads, so an all-FFFF search still names a winner
          ld = 1'b1;
          if (NUM_GROUPS == 1) begin
            state_nx   = DONE;
            grp_cnt_nx = '0;
          end else begin
            state_nx   = ACCUM;
            grp_cnt_nx = GRP_W'(1);
          end
        end
      end
      (state == ACCUM): begin
        in_rdy = 1'b1;
        bsy    = 1'b1;
        if (accept) begin
          upd = 1'b1;
          if (grp_cnt == LAST_GRP) begin
            state_nx   = DONE;
            grp_cnt_nx = '0;
          end else begin
            grp_cnt_nx = grp_cnt + GRP_W'(1);
          end
        end
      end
      (state == DONE): begin
        out_vld = 1'b1;
        bsy     = 1'b1;
        if (bus.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx   = IDLE;
        grp_cnt_nx = '0;
      end
    endcase
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.busy      = bsy;
  assign bus.win_idx   = out_vld ? best_idx : '0;
  assign bus.win_dist  = out_vld ? best_dist : '0;

endmodule

// File: tb/tb_centroid_winner_seq.sv
// Self-checking bench for centroid_winner_seq (NUM_GROUPS=4).
// Directed scenarios plus randomized searches against a flat-scan model.
module tb_centroid_winner_seq;
  import destin_defs::*;

  localparam int NG = 4;
  localparam int GW = 2;

  typedef logic [7:0][15:0] grp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  centroid_winner_seq_if #(.GRP_W(GW)) bus ();

  centroid_winner_seq #(
    .NUM_GROUPS (NG),
    .GRP_W      (GW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  grp_t        grps [NG];
  logic [4:0]  exp_idx;
  logic [15:0] exp_dist;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input grp_t g);
    bus.in_valid = v;
    bus.d_000 = g[0];
    bus.d_001 = g[1];
    bus.d_010 = g[2];
    bus.d_011 = g[3];
    bus.d_100 = g[4];
    bus.d_101 = g[5];
    bus.d_110 = g[6];
    bus.d_111 = g[7];
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic grp_t rand_grp();
    grp_t g;
    for (int i = 0; i < 8; i++) g[i] = 16'($urandom);
    return g;
  endfunction

  function automatic grp_t make_grp(input logic [15:0] mn,
                                    input int arg);
    grp_t g;
    for (int i = 0; i < 8; i++) begin
      if (i == arg) g[i] = mn;
      else g[i] = 16'($urandom_range(65535, int'(mn) + 1));
    end
    return g;
  endfunction

  // Winner = smallest of all 32 distances; first occurrence in
  // group-major order resolves every kind of tie.
  task automatic model();
    exp_dist = 16'hFFFF;
    exp_idx  = '0;
    for (int k = 0; k < NG * 8; k++) begin
      if (k == 0 || grps[k / 8][k % 8] < exp_dist) begin
        exp_dist = grps[k / 8][k % 8];
        exp_idx  = 5'(k);
      end
    end
  endtask

  // Feeds grps[] following a valid pattern (bit c = in_valid in cycle c).
  task automatic feed(input string tag, input logic [15:0] pat,
                      input int len);
    int gi = 0;
    for (int c = 0; c < len; c++) begin
      if (pat[c] && gi < NG) drive(1'b1, grps[gi]);
      else drive(1'b0, rand_grp());
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      check({tag, "_no_early_valid"}, 32'(bus.out_valid), 32'd0);
      cycle();
      if (pat[c]) gi++;
    end
    drive(1'b0, rand_grp());
    check({tag, "_accepts"}, 32'(gi), 32'(NG));
  endtask

  task automatic check_result(input string tag);
    model();
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_win_idx"}, 32'(bus.win_idx), 32'(exp_idx));
    check({tag, "_win_dist"}, 32'(bus.win_dist), 32'(exp_dist));
    check({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    drive(1'b0, rand_grp());
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;

    // reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_win_idx", 32'(bus.win_idx), 32'd0);
    check("rst_win_dist", 32'(bus.win_dist), 32'd0);

    // distinct minima, winner g1 arg 6
    grps[0] = make_grp(16'd500, 3);
    grps[1] = make_grp(16'd120, 6);
    grps[2] = make_grp(16'd300, 1);
    grps[3] = make_grp(16'd800, 7);
    feed("basic", 16'h000F, 4);
    check_result("basic");
    check("basic_idx_const", 32'(bus.win_idx), 32'd14);
    check("basic_dist_const", 32'(bus.win_dist), 32'd120);
    release_result("basic");

    // cross-group tie: earlier group wins
    grps[0] = make_grp(16'd77, 2);
    grps[1] = make_grp(16'd200, 4);
    grps[2] = make_grp(16'd77, 5);
    grps[3] = make_grp(16'd300, 0);
    feed("tie", 16'h000F, 4);
    check_result("tie");
    check("tie_idx_const", 32'(bus.win_idx), 32'd2);
    release_result("tie");

    // gaps in in_valid: 1,0,0,1,1,0,1
    grps[0] = make_grp(16'd900, 0);
    grps[1] = make_grp(16'd700, 4);
    grps[2] = make_grp(16'd650, 2);
    grps[3] = make_grp(16'd651, 5);
    feed("gaps", 16'b1011001, 7);
    check_result("gaps");
    check("gaps_idx_const", 32'(bus.win_idx), 32'd18);

    // hold with out_ready low while new data is offered
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, make_grp(16'd1, 0));
      cycle();
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_idx", 32'(bus.win_idx), 32'd18);
      check("hold_dist", 32'(bus.win_dist), 32'd650);
    end
    drive(1'b0, rand_grp());
    release_result("hold");

    // fresh search must not inherit the previous minimum
    grps[0] = make_grp(16'd41000, 1);
    grps[1] = make_grp(16'd42000, 2);
    grps[2] = make_grp(16'd40000, 4);
    grps[3] = make_grp(16'd43000, 3);
    feed("clean", 16'h000F, 4);
    check_result("clean");
    check("clean_idx_const", 32'(bus.win_idx), 32'd20);
    release_result("clean");

    // reset mid-search discards the partial result
    grps[0] = make_grp(16'd2, 1);
    grps[1] = make_grp(16'd3, 2);
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, grps[c]);
      cycle();
    end
    drive(1'b0, rand_grp());
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("midrst_no_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      cycle();
    end
    grps[0] = make_grp(16'd100, 2);
    grps[1] = make_grp(16'd50, 6);
    grps[2] = make_grp(16'd60, 1);
    grps[3] = make_grp(16'd9, 0);
    feed("midrst", 16'h000F, 4);
    check_result("midrst");
    check("midrst_idx_const", 32'(bus.win_idx), 32'd24);
    check("midrst_dist_const", 32'(bus.win_dist), 32'd9);
    release_result("midrst");

    // all distances FFFF
    for (int g = 0; g < NG; g++) grps[g] = '1;
    feed("allff", 16'h000F, 4);
    check_result("allff");
    check("allff_dist_const", 32'(bus.win_dist), 32'hFFFF);
    release_result("allff");

    // randomized searches: narrow value range to provoke ties
    for (int t = 0; t < 25; t++) begin
      logic [15:0] pat;
      int          len;
      int          dly;
      for (int g = 0; g < NG; g++)
        for (int i = 0; i < 8; i++)
          grps[g][i] = 16'($urandom_range(40, 0));
      pat = '0;
      len = 0;
      for (int ones = 0; ones < NG; ) begin
        if ($urandom_range(2, 0) != 0) begin
          pat[len] = 1'b1;
          ones++;
        end
        len++;
      end
      feed("rand", pat, len);
      dly = $urandom_range(3, 0);
      for (int c = 0; c < dly; c++) begin
        drive(1'b1, rand_grp());
        cycle();
      end
      drive(1'b0, rand_grp());
      check_result("rand");
      release_result("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
